vsram_access_arbiter: RTL and testbench

- Shares the two read ports and two write ports of the 512x48 dual-read/dual-write SRAM (v_sram_op4) among NREQ requesters.
- Each cycle it grants up to two reads and up to two writes, using independent round-robin pointers for reads and writes.
- Registers all SRAM inputs, captures read data, and returns it to the originating requester with fixed latency.
- Hides the SRAM's shared-WE quirk and write-write address collisions from requesters.

---
 rtl/vsram_access_arbiter.sv | 172 +++++++++++++++++
 tb/tb_vsram_access_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsram_access_arbiter.sv
// Round-robin arbiter sharing a dual-read/dual-write SRAM among NREQ requesters.
// Grants up to two reads and two writes per cycle; read data returns two cycles after acceptance.
module vsram_access_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 9,
  parameter int DW   = 48
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     rd_valid,
  input  logic [NREQ*AW-1:0]  rd_addr,
  output logic [NREQ-1:0]     rd_ready,
  input  logic [NREQ-1:0]     wr_valid,
  input  logic [NREQ*AW-1:0]  wr_addr,
  input  logic [NREQ*DW-1:0]  wr_data,
  output logic [NREQ-1:0]     wr_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [NREQ*DW-1:0]  rsp_data,
  output logic                sram_we,
  output logic [AW-1:0]       sram_waddr1,
  output logic [AW-1:0]       sram_waddr2,
  output logic [DW-1:0]       sram_wdata1,
  output logic [DW-1:0]       sram_wdata2,
  output logic [AW-1:0]       sram_raddr1,
  output logic [AW-1:0]       sram_raddr2,
  input  logic [DW-1:0]       sram_rdata1,
  input  logic [DW-1:0]       sram_rdata2
);

  localparam int PW = $clog2(NREQ);
  typedef logic [PW-1:0] idx_t;

  function automatic idx_t wrap_add(input idx_t base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return idx_t'(sum);
  endfunction

  logic [AW-1:0] rd_addr_arr [NREQ];
  logic [AW-1:0] wr_addr_arr [NREQ];
  logic [DW-1:0] wr_data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rd_addr_arr[g] = rd_addr[g*AW +: AW];
    assign wr_addr_arr[g] = wr_addr[g*AW +: AW];
    assign wr_data_arr[g] = wr_data[g*DW +: DW];
  end

  idx_t rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  idx_t rd_idx, wr_idx;
  idx_t rd_sel1, rd_sel2, wr_sel1, wr_sel2;
  logic rd_hit1, rd_hit2, wr_hit1, wr_hit2;
  idx_t tag1, tag2;
  logic tag1_valid, tag2_valid;

  // Read scan: first two valid requesters starting at rd_ptr
  always_comb begin
    rd_idx  = '0;
    rd_hit1 = 1'b0;
    rd_hit2 = 1'b0;
    rd_sel1 = '0;
    rd_sel2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      rd_idx = wrap_add(rd_ptr, k);
      if (rd_valid[rd_idx] && !rd_hit1) begin
        rd_hit1 = 1'b1;
        rd_sel1 = rd_idx;
      end else if (rd_valid[rd_idx] && !rd_hit2) begin
        rd_hit2 = 1'b1;
        rd_sel2 = rd_idx;
      end else begin
        rd_hit2 = rd_hit2;
      end
    end
  end

  // Write scan: a second candidate that collides with the first grant's address is skipped
  always_comb begin
    wr_idx  = '0;
    wr_hit1 = 1'b0;
    wr_hit2 = 1'b0;
    wr_sel1 = '0;
    wr_sel2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      wr_idx = wrap_add(wr_ptr, k);
      if (wr_valid[wr_idx] && !wr_hit1) begin
        wr_hit1 = 1'b1;
        wr_sel1 = wr_idx;
      end else if (wr_valid[wr_idx] && !wr_hit2 &&
                   (wr_addr_arr[wr_idx] != wr_addr_arr[wr_sel1])) begin
        wr_hit2 = 1'b1;
        wr_sel2 = wr_idx;
      end else begin
        wr_hit2 = wr_hit2;
      end
    end
  end

  // Grant vectors and pointer advance past the last grant
  always_comb begin
    rd_ready          = '0;
    wr_ready          = '0;
    rd_ready[rd_sel1] = rd_hit1;
    rd_ready[rd_sel2] = rd_ready[rd_sel2] | rd_hit2;
    wr_ready[wr_sel1] = wr_hit1;
    wr_ready[wr_sel2] = wr_ready[wr_sel2] | wr_hit2;
    rd_ptr_next = rd_hit2 ? wrap_add(rd_sel2, 1) : (rd_hit1 ? wrap_add(rd_sel1, 1) : rd_ptr);
    wr_ptr_next = wr_hit2 ? wrap_add(wr_sel2, 1) : (wr_hit1 ? wrap_add(wr_sel1, 1) : wr_ptr);
  end

  // Pointers, registered SRAM drive and the read tag stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      sram_we     <= 1'b0;
      sram_waddr1 <= '0;
      sram_waddr2 <= '0;
      sram_wdata1 <= '0;
      sram_wdata2 <= '0;
      sram_raddr1 <= '0;
      sram_raddr2 <= '0;
      tag1        <= '0;
      tag2        <= '0;
      tag1_valid  <= 1'b0;
      tag2_valid  <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_next;
      wr_ptr     <= wr_ptr_next;
      tag1       <= rd_sel1;
      tag2       <= rd_sel2;
      tag1_valid <= rd_hit1;
      tag2_valid <= rd_hit2;
      if (rd_hit1) begin
        sram_raddr1 <= rd_addr_arr[rd_sel1];
        sram_raddr2 <= rd_hit2 ? rd_addr_arr[rd_sel2] : rd_addr_arr[rd_sel1];
      end
      // WE is shared, so a lone write is duplicated onto both ports
      sram_we <= wr_hit1;
      if (wr_hit1) begin
        sram_waddr1 <= wr_addr_arr[wr_sel1];
        sram_wdata1 <= wr_data_arr[wr_sel1];
        sram_waddr2 <= wr_hit2 ? wr_addr_arr[wr_sel2] : wr_addr_arr[wr_sel1];
        sram_wdata2 <= wr_hit2 ? wr_data_arr[wr_sel2] : wr_data_arr[wr_sel1];
      end
    end
  end

  // Capture read data into the lane of the requester that issued it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (tag1_valid && (tag1 == idx_t'(i))) begin
          rsp_valid[i]           <= 1'b1;
          rsp_data[i*DW +: DW]   <= sram_rdata1;
        end else if (tag2_valid && (tag2 == idx_t'(i))) begin
          rsp_valid[i]           <= 1'b1;
          rsp_data[i*DW +: DW]   <= sram_rdata2;
        end else begin
          rsp_valid[i]           <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vsram_access_arbiter.sv
// Bench for vsram_access_arbiter: directed scenarios then random traffic,
// checked against a queue-based arbitration model and a reference memory.
module tb_vsram_access_arbiter;

  localparam int NREQ  = 4;
  localparam int AW    = 9;
  localparam int DW    = 48;
  localparam int MEMSZ = 1 << AW;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   rd_valid = '0;
  logic [NREQ*AW-1:0] rd_addr = '0;
  logic [NREQ-1:0]   rd_ready;
  logic [NREQ-1:0]   wr_valid = '0;
  logic [NREQ*AW-1:0] wr_addr = '0;
  logic [NREQ*DW-1:0] wr_data = '0;
  logic [NREQ-1:0]   wr_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ*DW-1:0] rsp_data;
  logic              sram_we;
  logic [AW-1:0]     sram_waddr1, sram_waddr2, sram_raddr1, sram_raddr2;
  logic [DW-1:0]     sram_wdata1, sram_wdata2, sram_rdata1, sram_rdata2;

  vsram_access_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sram_we(sram_we),
    .sram_waddr1(sram_waddr1), .sram_waddr2(sram_waddr2),
    .sram_wdata1(sram_wdata1), .sram_wdata2(sram_wdata2),
    .sram_raddr1(sram_raddr1), .sram_raddr2(sram_raddr2),
    .sram_rdata1(sram_rdata1), .sram_rdata2(sram_rdata2)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_word(input int a);
    logic [15:0] a16;
    a16 = 16'(a);
    return {16'hC0DE, a16, 16'h5A5A};
  endfunction

  // SRAM environment: asynchronous read, both ports written on WE
  logic [DW-1:0] sram_mem [MEMSZ];
  always @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < MEMSZ; a++) sram_mem[a] <= init_word(a);
    end else if (sram_we) begin
      sram_mem[sram_waddr1] <= sram_wdata1;
      sram_mem[sram_waddr2] <= sram_wdata2;
    end
  end
  assign sram_rdata1 = sram_mem[sram_raddr1];
  assign sram_rdata2 = sram_mem[sram_raddr2];

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0]   ref_mem [MEMSZ];
  int              m_rd_ptr, m_wr_ptr;
  logic [NREQ-1:0] pend_v;
  logic [DW-1:0]   pend_d [NREQ];
  int              rd_age [NREQ];
  logic [NREQ-1:0] seen_rd_ready, seen_wr_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [AW-1:0] rd_lane_addr(input int i);
    return rd_addr[i*AW +: AW];
  endfunction
  function automatic logic [AW-1:0] wr_lane_addr(input int i);
    return wr_addr[i*AW +: AW];
  endfunction
  function automatic logic [DW-1:0] wr_lane_data(input int i);
    return wr_data[i*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] rsp_lane(input int i);
    return rsp_data[i*DW +: DW];
  endfunction

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
    rd_valid[i] = 1'b1;
  endtask
  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
    wr_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rd_valid = '0;
    wr_valid = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
    check_eq("rst_sram_we", 64'(sram_we), 64'd0);
    check_eq("rst_waddr", 64'({sram_waddr1, sram_waddr2}), 64'd0);
    check_eq("rst_wdata1", 64'(sram_wdata1), 64'd0);
    check_eq("rst_wdata2", 64'(sram_wdata2), 64'd0);
    check_eq("rst_raddr", 64'({sram_raddr1, sram_raddr2}), 64'd0);
    m_rd_ptr = 0;
    m_wr_ptr = 0;
    pend_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend_d[i] = '0;
      rd_age[i] = 0;
    end
    for (int a = 0; a < MEMSZ; a++) ref_mem[a] = init_word(a);
    reset = 1'b0;
  endtask

  // One clock of the reference model: predict grants, check them, advance, check registered outputs
  task automatic run_cycle();
    int rc[$];
    int wc[$];
    int r1, r2, w1, w2;
    logic [NREQ-1:0] erd, ewr, nx_v;
    logic [DW-1:0]   nx_d [NREQ];
    logic            exp_we;
    logic [AW-1:0]   ewa1, ewa2, era1, era2;
    logic [DW-1:0]   ewd1, ewd2;
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (rd_valid[(m_rd_ptr + k) % NREQ]) rc.push_back((m_rd_ptr + k) % NREQ);
      if (wr_valid[(m_wr_ptr + k) % NREQ]) wc.push_back((m_wr_ptr + k) % NREQ);
    end
    r1 = -1; r2 = -1; w1 = -1; w2 = -1;
    if (rc.size() > 0) r1 = rc[0];
    if (rc.size() > 1) r2 = rc[1];
    if (wc.size() > 0) w1 = wc[0];
    for (int n = 1; n < wc.size(); n++)
      if (w2 < 0 && wr_lane_addr(wc[n]) != wr_lane_addr(w1)) w2 = wc[n];
    erd = '0; ewr = '0;
    if (r1 >= 0) erd[r1] = 1'b1;
    if (r2 >= 0) erd[r2] = 1'b1;
    if (w1 >= 0) ewr[w1] = 1'b1;
    if (w2 >= 0) ewr[w2] = 1'b1;
    seen_rd_ready = rd_ready;
    seen_wr_ready = wr_ready;
    check_eq("rd_ready", 64'(rd_ready), 64'(erd));
    check_eq("wr_ready", 64'(wr_ready), 64'(ewr));
    for (int i = 0; i < NREQ; i++) begin
      if (rd_valid[i]) rd_age[i]++;
      else rd_age[i] = 0;
      if (erd[i]) begin
        check_eq("rd_fairness", 64'(rd_age[i] <= (NREQ + 1) / 2), 64'd1);
        rd_age[i] = 0;
      end
      nx_d[i] = erd[i] ? ref_mem[rd_lane_addr(i)] : '0;
    end
    nx_v = erd;
    exp_we = (w1 >= 0);
    ewa1 = '0; ewa2 = '0; ewd1 = '0; ewd2 = '0; era1 = '0; era2 = '0;
    if (w1 >= 0) begin
      ewa1 = wr_lane_addr(w1); ewd1 = wr_lane_data(w1);
      ewa2 = ewa1; ewd2 = ewd1;
    end
    if (w2 >= 0) begin
      ewa2 = wr_lane_addr(w2); ewd2 = wr_lane_data(w2);
    end
    if (r1 >= 0) begin
      era1 = rd_lane_addr(r1);
      era2 = era1;
    end
    if (r2 >= 0) era2 = rd_lane_addr(r2);
    // reads taken this cycle saw memory before this cycle's writes
    if (w1 >= 0) ref_mem[ewa1] = ewd1;
    if (w2 >= 0) ref_mem[ewa2] = ewd2;
    if (r2 >= 0) m_rd_ptr = (r2 + 1) % NREQ;
    else if (r1 >= 0) m_rd_ptr = (r1 + 1) % NREQ;
    if (w2 >= 0) m_wr_ptr = (w2 + 1) % NREQ;
    else if (w1 >= 0) m_wr_ptr = (w1 + 1) % NREQ;

    @(posedge clock);
    #1;
    check_eq("rsp_valid", 64'(rsp_valid), 64'(pend_v));
    for (int i = 0; i < NREQ; i++)
      if (pend_v[i]) check_eq($sformatf("rsp_data%0d", i), 64'(rsp_lane(i)), 64'(pend_d[i]));
    pend_v = nx_v;
    for (int i = 0; i < NREQ; i++) pend_d[i] = nx_d[i];
    check_eq("sram_we", 64'(sram_we), 64'(exp_we));
    if (exp_we) begin
      check_eq("sram_waddr1", 64'(sram_waddr1), 64'(ewa1));
      check_eq("sram_waddr2", 64'(sram_waddr2), 64'(ewa2));
      check_eq("sram_wdata1", 64'(sram_wdata1), 64'(ewd1));
      check_eq("sram_wdata2", 64'(sram_wdata2), 64'(ewd2));
    end
    if (r1 >= 0) begin
      check_eq("sram_raddr1", 64'(sram_raddr1), 64'(era1));
      check_eq("sram_raddr2", 64'(sram_raddr2), 64'(era2));
    end
  endtask

  initial begin
    logic [63:0] r64;
    do_reset();

    // Reset with a read in flight: no response may appear
    set_rd(0, 9'h010);
    run_cycle();
    rd_valid = '0;
    do_reset();
    run_cycle();
    check_eq("rst_mid_read_no_rsp", 64'(rsp_valid), 64'd0);

    // Four readers from rd_ptr=0
    for (int i = 0; i < NREQ; i++) set_rd(i, AW'(9'h010 + i));
    run_cycle();
    check_eq("four_rd_c1", 64'(seen_rd_ready), 64'h3);
    run_cycle();
    check_eq("four_rd_c2", 64'(seen_rd_ready), 64'hC);
    check_eq("four_rd_rsp1", 64'(rsp_valid), 64'h3);
    check_eq("four_rd_rsp1_d1", 64'(rsp_lane(1)), 64'(init_word(9'h011)));
    run_cycle();
    check_eq("four_rd_c3", 64'(seen_rd_ready), 64'h3);
    check_eq("four_rd_rsp2_d3", 64'(rsp_lane(3)), 64'(init_word(9'h013)));
    rd_valid = '0;
    run_cycle();
    run_cycle();

    // Lone write is duplicated on both ports, then read back by req2
    set_wr(0, 9'h005, 48'h0000_1234_5678);
    run_cycle();
    wr_valid = '0;
    check_eq("single_we", 64'(sram_we), 64'd1);
    check_eq("single_waddr", 64'({sram_waddr1, sram_waddr2}), 64'({9'h005, 9'h005}));
    check_eq("single_wdata1", 64'(sram_wdata1), 64'h0000_1234_5678);
    check_eq("single_wdata2", 64'(sram_wdata2), 64'h0000_1234_5678);
    set_rd(2, 9'h005);
    run_cycle();
    rd_valid = '0;
    run_cycle();
    check_eq("single_rd_valid", 64'(rsp_valid), 64'h4);
    check_eq("single_rd_data", 64'(rsp_lane(2)), 64'h0000_1234_5678);

    // Write-write collision with wr_ptr=1
    set_wr(1, 9'h1FF, 48'h1111_0000_0001);
    set_wr(2, 9'h1FF, 48'h2222_0000_0002);
    set_wr(3, 9'h000, 48'h3333_0000_0003);
    run_cycle();
    check_eq("coll_grant1", 64'(seen_wr_ready), 64'hA);
    check_eq("coll_waddr", 64'({sram_waddr1, sram_waddr2}), 64'({9'h1FF, 9'h000}));
    wr_valid[1] = 1'b0;
    wr_valid[3] = 1'b0;
    run_cycle();
    check_eq("coll_grant2", 64'(seen_wr_ready), 64'h4);
    wr_valid = '0;
    set_rd(0, 9'h1FF);
    run_cycle();
    rd_valid = '0;
    run_cycle();
    check_eq("coll_final", 64'(rsp_lane(0)), 64'h2222_0000_0002);

    // Same-cycle read returns old data; next-cycle read returns new data
    set_wr(0, 9'h020, 48'h5555_5555_5555);
    run_cycle();
    set_wr(0, 9'h020, 48'hAAAA_AAAA_AAAA);
    set_rd(1, 9'h020);
    run_cycle();
    wr_valid = '0;
    run_cycle();
    rd_valid = '0;
    check_eq("raw_same_cycle", 64'(rsp_lane(1)), 64'h5555_5555_5555);
    run_cycle();
    check_eq("raw_next_cycle", 64'(rsp_lane(1)), 64'hAAAA_AAAA_AAAA);

    // Idle
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      check_eq("idle_we", 64'(sram_we), 64'd0);
      check_eq("idle_rsp", 64'(rsp_valid), 64'd0);
    end

    // Random traffic on a small address window to provoke collisions and hazards
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rd_valid[i] && $urandom_range(0, 1) == 1) set_rd(i, AW'($urandom_range(0, 15)));
        if (!wr_valid[i] && $urandom_range(0, 2) == 0) begin
          r64 = {$urandom, $urandom};
          set_wr(i, AW'($urandom_range(0, 15)), r64[DW-1:0]);
        end
      end
      run_cycle();
      rd_valid = rd_valid & ~seen_rd_ready;
      wr_valid = wr_valid & ~seen_wr_ready;
    end
    rd_valid = '0;
    wr_valid = '0;
    run_cycle();
    run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
